// File: rtl/bsg_link_iddr_align_pkg.sv
// Shared types and training-pattern helpers for the DDR receive alignment controller.
package bsg_link_iddr_align_pkg;

  localparam int unsigned MAX_WIDTH = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_LOCK,
    S_TRAINED,
    S_RUN,
    S_FAIL
  } state_e;

  // Patterns are built at MAX_WIDTH and sliced down by the user to 2*w bits.
  function automatic logic [2*MAX_WIDTH-1:0] pat_norm(input int unsigned w);
    logic [2*MAX_WIDTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < w; i++) p[w+i] = 1'b1;
    return p;
  endfunction

  function automatic logic [2*MAX_WIDTH-1:0] pat_swap(input int unsigned w);
    logic [2*MAX_WIDTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < w; i++) p[i] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/bsg_link_iddr_half_swap.sv
// Half-word realignment: optionally splices the current lower half above the
// previous cycle's upper half to undo a half-cycle capture skew.
module bsg_link_iddr_half_swap
  import bsg_link_iddr_align_pkg::*;
#(
  parameter int unsigned width_p = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_swap,
  input  logic [2*width_p-1:0] i_data,
  output logic [2*width_p-1:0] o_data
);

  logic [width_p-1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev <= '0;
    else         r_prev <= i_data[2*width_p-1:width_p];
  end

  assign o_data = i_swap ? {i_data[width_p-1:0], r_prev} : i_data;

endmodule

// File: rtl/bsg_link_iddr_align_ctrl.sv
// Receive-side training FSM: finds the training pattern, picks the half-word
// orientation after lock_count_p consecutive matches, then streams aligned words.
module bsg_link_iddr_align_ctrl
  import bsg_link_iddr_align_pkg::*;
#(
  parameter int unsigned width_p      = 64,
  parameter int unsigned lock_count_p = 8,
  parameter int unsigned timeout_p    = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 train_i,
  input  logic [2*width_p-1:0] phy_data_i,
  output logic [2*width_p-1:0] data_o,
  output logic                 data_v_o,
  output logic                 aligned_o,
  output logic                 swap_o,
  output logic                 fail_o
);

  localparam int unsigned TW = $clog2(timeout_p + 1);
  localparam int unsigned CW = $clog2(lock_count_p + 1);

  localparam logic [TW-1:0] TMO_LAST = TW'(timeout_p - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(timeout_p);
  localparam logic [CW-1:0] CNT_LOCK = CW'(lock_count_p);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2*MAX_WIDTH-1:0] P_NORM_FULL = pat_norm(width_p);
  localparam logic [2*MAX_WIDTH-1:0] P_SWAP_FULL = pat_swap(width_p);
  localparam logic [2*width_p-1:0]   P_NORM      = P_NORM_FULL[2*width_p-1:0];
  localparam logic [2*width_p-1:0]   P_SWAP      = P_SWAP_FULL[2*width_p-1:0];

  state_e               r_state, w_state_n;
  logic [TW-1:0]        r_timer, w_timer_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic                 r_cand, w_cand_n;
  logic                 r_swap, w_swap_n;
  logic                 r_aligned, w_aligned_n;
  logic                 r_fail, w_fail_n;
  logic [2*width_p-1:0] r_data, w_data_n;
  logic                 r_data_v, w_data_v_n;
  logic                 r_train_d;

  logic [2*width_p-1:0] w_aligned_word;
  logic                 w_rise, w_is_norm, w_is_swap, w_cand_match;
  logic                 w_timeout, w_lock_done;
  logic [TW-1:0]        w_timer_inc;
  logic [CW-1:0]        w_cnt_inc;

  bsg_link_iddr_half_swap #(.width_p(width_p)) u_half_swap (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_swap  (r_swap),
    .i_data  (phy_data_i),
    .o_data  (w_aligned_word)
  );

  assign w_rise       = train_i & ~r_train_d;
  assign w_is_norm    = (phy_data_i == P_NORM);
  assign w_is_swap    = (phy_data_i == P_SWAP);
  assign w_cand_match = r_cand ? w_is_swap : w_is_norm;
  assign w_timer_inc  = (r_timer == TMO_MAX) ? r_timer : r_timer + 1'b1;
  assign w_timeout    = (r_timer == TMO_LAST);
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_lock_done  = w_cand_match && (w_cnt_inc == CNT_LOCK);

  always_comb begin
    w_state_n   = r_state;
    w_timer_n   = r_timer;
    w_cnt_n     = r_cnt;
    w_cand_n    = r_cand;
    w_swap_n    = r_swap;
    w_aligned_n = r_aligned;
    w_fail_n    = r_fail;
    w_data_n    = r_data;
    w_data_v_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (train_i) begin
          w_state_n = S_SEARCH;
          w_timer_n = '0;
          w_cnt_n   = '0;
        end
      end
      S_SEARCH: begin
        if (!train_i) begin
          w_state_n = S_IDLE;
          w_timer_n = '0;
          w_cnt_n   = '0;
        end else if (w_timeout) begin
          w_state_n   = S_FAIL;
          w_fail_n    = 1'b1;
          w_aligned_n = 1'b0;
        end else begin
          w_timer_n = w_timer_inc;
          if (w_is_norm || w_is_swap) begin
            w_cand_n  = w_is_swap;
            w_cnt_n   = CNT_ONE;
            w_state_n = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        // Lock completion outranks a coincident timeout.
        if (!train_i) begin
          w_state_n = S_IDLE;
          w_timer_n = '0;
          w_cnt_n   = '0;
        end else if (w_lock_done) begin
          w_state_n   = S_TRAINED;
          w_cnt_n     = w_cnt_inc;
          w_timer_n   = w_timer_inc;
          w_swap_n    = r_cand;
          w_aligned_n = 1'b1;
        end else if (w_timeout) begin
          w_state_n   = S_FAIL;
          w_fail_n    = 1'b1;
          w_aligned_n = 1'b0;
        end else if (w_cand_match) begin
          w_cnt_n   = w_cnt_inc;
          w_timer_n = w_timer_inc;
        end else begin
          w_cnt_n   = '0;
          w_timer_n = w_timer_inc;
          w_state_n = S_SEARCH;
        end
      end
      S_TRAINED: begin
        if (!train_i) w_state_n = S_RUN;
      end
      S_RUN: begin
        if (w_rise) begin
          w_state_n   = S_SEARCH;
          w_aligned_n = 1'b0;
          w_timer_n   = '0;
          w_cnt_n     = '0;
        end else begin
          w_data_n   = w_aligned_word;
          w_data_v_n = 1'b1;
        end
      end
      S_FAIL: begin
        if (w_rise) begin
          w_state_n = S_SEARCH;
          w_fail_n  = 1'b0;
          w_timer_n = '0;
          w_cnt_n   = '0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_cnt     <= '0;
      r_cand    <= 1'b0;
      r_swap    <= 1'b0;
      r_aligned <= 1'b0;
      r_fail    <= 1'b0;
      r_data    <= '0;
      r_data_v  <= 1'b0;
      r_train_d <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_timer   <= w_timer_n;
      r_cnt     <= w_cnt_n;
      r_cand    <= w_cand_n;
      r_swap    <= w_swap_n;
      r_aligned <= w_aligned_n;
      r_fail    <= w_fail_n;
      r_data    <= w_data_n;
      r_data_v  <= w_data_v_n;
      r_train_d <= train_i;
    end
  end

  assign data_o    = r_data;
  assign data_v_o  = r_data_v;
  assign aligned_o = r_aligned;
  assign swap_o    = r_swap;
  assign fail_o    = r_fail;

endmodule
